// File: rtl/machine_timer_unit.sv
// Purpose : memory-mapped machine timer (64-bit mtime/mtimecmp) and msip bit feeding the CSR file.
// Latency : one request accepted in IDLE; its response is valid on the following cycle.
// Backpr. : single outstanding; o_req_ready stays low while a response waits for i_rsp_ready.
//
// Ports:
//   clk, arst               clock; asynchronous active-high reset
//   i_req_valid/o_req_ready request handshake (accepted when both high)
//   i_req_write/addr/wdata  request payload (word address into the register window)
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_rdata/o_rsp_err   read data (0 for writes) and unmapped-address flag
//   o_timer_int_call        registered (mtime >= mtimecmp)
//   o_software_int_call     msip bit
//
// Register window (word address):
//   0 MSIP (bit0 only), 1 MTIMECMP_LO, 2 MTIMECMP_HI, 3 MTIME_LO, 4 MTIME_HI, 5..7 unmapped.

module machine_timer_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_timer_int_call,
  output logic                  o_software_int_call
);

  // Register window decode
  localparam logic [ADDR_WIDTH-1:0] ADDR_MSIP        = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MTIMECMP_LO = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MTIMECMP_HI = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_LO    = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME_HI    = ADDR_WIDTH'(4);

  // Prescale counter is 16 bits wide, enough for PRESCALE up to 65535.
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  msip_q, msip_d;
  logic [15:0]           presc_q, presc_d;
  logic [31:0]           hi_shadow_q, hi_shadow_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  timer_int_q, timer_int_d;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                  req_acc;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  sel_msip;
  logic                  sel_cmp_lo;
  logic                  sel_cmp_hi;
  logic                  sel_mtime_lo;
  logic                  sel_mtime_hi;
  logic                  addr_mapped;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  presc_tick;

  assign req_acc = i_req_valid & o_req_ready;
  assign wr_acc  = req_acc & i_req_write;
  assign rd_acc  = req_acc & ~i_req_write;

  always_comb begin
    sel_msip     = 1'b0;
    sel_cmp_lo   = 1'b0;
    sel_cmp_hi   = 1'b0;
    sel_mtime_lo = 1'b0;
    sel_mtime_hi = 1'b0;
    case (i_req_addr)
      ADDR_MSIP:        sel_msip     = 1'b1;
      ADDR_MTIMECMP_LO: sel_cmp_lo   = 1'b1;
      ADDR_MTIMECMP_HI: sel_cmp_hi   = 1'b1;
      ADDR_MTIME_LO:    sel_mtime_lo = 1'b1;
      ADDR_MTIME_HI:    sel_mtime_hi = 1'b1;
      default:          ;
    endcase
    addr_mapped = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mtime_lo | sel_mtime_hi;
  end

  // Read mux works on pre-edge register values, so a read never observes the
  // update (increment or write) happening at its own accept edge.
  // MTIME_HI returns the shadow captured by the last MTIME_LO read (or MTIME_HI
  // write), giving software a coherent 64-bit snapshot across a carry.
  always_comb begin
    rd_data = '0;
    if (sel_msip)     rd_data = {{(DATA_WIDTH-1){1'b0}}, msip_q};
    if (sel_cmp_lo)   rd_data = mtimecmp_q[31:0];
    if (sel_cmp_hi)   rd_data = mtimecmp_q[63:32];
    if (sel_mtime_lo) rd_data = mtime_q[31:0];
    if (sel_mtime_hi) rd_data = hi_shadow_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_tick = (presc_q == PRESC_LAST);
    presc_d    = presc_tick ? 16'd0 : presc_q + 16'd1;

    // Free-running count; wraps silently at 2^64.
    mtime_d = mtime_q + 64'(presc_tick);
    // A software write wins over a coincident tick: the tick is dropped and
    // the untouched half keeps its pre-edge value (no carry from the tick).
    // The prescaler keeps running regardless of mtime writes.
    if (wr_acc && sel_mtime_lo) mtime_d = {mtime_q[63:32], i_req_wdata};
    if (wr_acc && sel_mtime_hi) mtime_d = {i_req_wdata, mtime_q[31:0]};

    mtimecmp_d = mtimecmp_q;
    if (wr_acc && sel_cmp_lo) mtimecmp_d[31:0]  = i_req_wdata;
    if (wr_acc && sel_cmp_hi) mtimecmp_d[63:32] = i_req_wdata;

    msip_d = msip_q;
    if (wr_acc && sel_msip) msip_d = i_req_wdata[0];

    hi_shadow_d = hi_shadow_q;
    if (rd_acc && sel_mtime_lo) hi_shadow_d = mtime_q[63:32];
    if (wr_acc && sel_mtime_hi) hi_shadow_d = i_req_wdata;

    // Response payload is captured only at accept and then held for the whole
    // RESP phase, which keeps it stable under backpressure.
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (req_acc) begin
      rsp_rdata_d = i_req_write ? '0 : rd_data;
      rsp_err_d   = ~addr_mapped;
    end

    // Compare on current register values; the output lags the condition by
    // one cycle, which keeps the 64-bit compare off the CSR input path.
    timer_int_d = (mtime_q >= mtimecmp_q);
  end

  // ---------------------------------------------------------------------------
  // Bus FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req_valid) state_d = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // No accept while a response is outstanding, even in the cycle it drains.
  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: o_req_ready = 1'b1;
      ST_RESP: o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mtime_q     <= 64'd0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q      <= 1'b0;
      presc_q     <= 16'd0;
      hi_shadow_q <= 32'd0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      presc_q     <= presc_d;
      hi_shadow_q <= hi_shadow_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign o_rsp_rdata         = rsp_rdata_q;
  assign o_rsp_err           = rsp_err_q;
  assign o_timer_int_call    = timer_int_q;
  assign o_software_int_call = msip_q;

endmodule

// File: tb/tb_machine_timer_unit.sv
// Purpose : directed bench for machine_timer_unit; instance A (PRESCALE=1), instance B (PRESCALE=4).
// Latency : bus tasks issue one request, expect the response the cycle after accept.
// Backpr. : responses normally drained immediately; selected requests stall i_rsp_ready.

module tb_machine_timer_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals (PRESCALE = 1)
  logic        a_arst, a_req_valid, a_req_ready, a_req_write;
  logic [2:0]  a_req_addr;
  logic [31:0] a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready;
  logic [31:0] a_rsp_rdata;
  logic        a_rsp_err, a_tint, a_sint;

  // Instance B signals (PRESCALE = 4)
  logic        b_arst, b_req_valid, b_req_ready, b_req_write;
  logic [2:0]  b_req_addr;
  logic [31:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err, b_tint, b_sint;

  machine_timer_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .PRESCALE(1)) u_dut_a (
    .clk(clk), .arst(a_arst),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_write(a_req_write),
    .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
    .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err),
    .o_timer_int_call(a_tint), .o_software_int_call(a_sint)
  );

  machine_timer_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .PRESCALE(4)) u_dut_b (
    .clk(clk), .arst(b_arst),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_write(b_req_write),
    .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
    .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err),
    .o_timer_int_call(b_tint), .o_software_int_call(b_sint)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic acc_tint, acc_sint;  // interrupt levels just after the accept edge

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: pop on each completed response handshake.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_rsp_valid === 1'b1 && a_rsp_ready === 1'b1) begin
      if (q_a.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_a_unexpected: got rdata %0h err %0b, expected no response", a_rsp_rdata, a_rsp_err);
      end else begin
        e = q_a.pop_front();
        chk("rsp_a_rdata", a_rsp_rdata, e.rdata);
        chk("rsp_a_err", a_rsp_err, e.err);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_rsp_valid === 1'b1 && b_rsp_ready === 1'b1) begin
      if (q_b.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_b_unexpected: got rdata %0h err %0b, expected no response", b_rsp_rdata, b_rsp_err);
      end else begin
        e = q_b.pop_front();
        chk("rsp_b_rdata", b_rsp_rdata, e.rdata);
        chk("rsp_b_err", b_rsp_err, e.err);
      end
    end
  end

  task automatic drive(input bit sel, input logic v, input logic w, input logic [2:0] ad, input logic [31:0] d);
    if (sel) begin
      b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = d;
    end else begin
      a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = d;
    end
  endtask

  task automatic set_rdy(input bit sel, input logic v);
    if (sel) b_rsp_ready = v; else a_rsp_ready = v;
  endtask

  // Called just after a clock edge E: accepts at E+1, returns just after E+2
  // (plus stall cycles). The read value is therefore mtime as it stood after E.
  task automatic do_req(input bit sel, input logic wr, input logic [2:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int stall);
    exp_t e;
    bit   got;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
    drive(sel, 1'b1, wr, addr, wdata);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = sel ? (b_req_ready === 1'b1) : (a_req_ready === 1'b1);
    end
    chk("req_ready_before_accept", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 3'd0, 32'd0);
    acc_tint = sel ? b_tint : a_tint;
    acc_sint = sel ? b_sint : a_sint;
    if (stall > 0) begin
      set_rdy(sel, 1'b0);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_rsp_valid", sel ? b_rsp_valid : a_rsp_valid, 1);
        chk("stall_req_ready", sel ? b_req_ready : a_req_ready, 0);
        chk("stall_rdata", sel ? b_rsp_rdata : a_rsp_rdata, exp_rdata);
        chk("stall_err", sel ? b_rsp_err : a_rsp_err, exp_err);
      end
      @(posedge clk); #1;
      set_rdy(sel, 1'b1);
    end
    @(negedge clk);
    chk("rsp_valid_after_accept", sel ? b_rsp_valid : a_rsp_valid, 1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    a_arst = 1'b1; b_arst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    acc_tint = 1'b0; acc_sint = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_rdata", a_rsp_rdata, 0);
    chk("rst_rsp_err", a_rsp_err, 0);
    chk("rst_timer_int", a_tint, 0);
    chk("rst_sw_int", a_sint, 0);
    @(posedge clk); #1;
    a_arst = 1'b0; b_arst = 1'b0;  // released just after edge R0

    // 1. Idle 10 cycles -> mtime = 10
    repeat (10) @(posedge clk); #1;
    chk("t1_timer_int", a_tint, 0);
    chk("t1_req_ready", a_req_ready, 1);
    do_req(0, 1'b0, 3'd3, 32'd0, 32'd10, 1'b0, 0);                 // ret after R12

    // 2. Timer compare rise and fall
    do_req(0, 1'b1, 3'd2, 32'd0, 32'd0, 1'b0, 0);                  // cmp_hi=0, ret R14
    do_req(0, 1'b1, 3'd1, 32'd20, 32'd0, 1'b0, 0);                 // cmp_lo=20, ret R16
    repeat (4) @(posedge clk);                                     // R20: mtime -> 20
    @(negedge clk);
    chk("t2_int_at_mtime20", a_tint, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t2_int_one_cycle_later", a_tint, 1);
    @(posedge clk); #1;                                            // after R22
    do_req(0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);          // accept R23
    chk("t2_int_after_write_edge", acc_tint, 1);
    chk("t2_int_fell", a_tint, 0);                                 // after R24

    // 3. mtime writes, carry, hi shadow
    do_req(0, 1'b1, 3'd4, 32'd0, 32'd0, 1'b0, 0);                  // mtime = 24, ret R26
    do_req(0, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);          // ret R28
    @(posedge clk); #1;                                            // mtime = 1_00000001
    do_req(0, 1'b0, 3'd3, 32'd0, 32'd1, 1'b0, 0);
    do_req(0, 1'b0, 3'd4, 32'd0, 32'd1, 1'b0, 0);
    do_req(0, 1'b1, 3'd4, 32'h1234, 32'd0, 1'b0, 0);
    do_req(0, 1'b0, 3'd4, 32'd0, 32'h1234, 1'b0, 0);
    do_req(0, 1'b1, 3'd3, 32'hFFFF_FFFE, 32'd0, 1'b0, 0);          // ret R39
    do_req(0, 1'b0, 3'd3, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);          // shadow = 1234
    do_req(0, 1'b0, 3'd4, 32'd0, 32'h1234, 1'b0, 0);               // live hi is 1235
    do_req(0, 1'b0, 3'd3, 32'd0, 32'd3, 1'b0, 0);
    do_req(0, 1'b0, 3'd4, 32'd0, 32'h1235, 1'b0, 0);

    // 4. MSIP
    do_req(0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
    chk("t4_sw_int_at_accept", acc_sint, 1);
    chk("t4_sw_int_set", a_sint, 1);
    do_req(0, 1'b0, 3'd0, 32'd0, 32'd1, 1'b0, 0);
    do_req(0, 1'b1, 3'd0, 32'd0, 32'd0, 1'b0, 0);
    chk("t4_sw_int_clr_at_accept", acc_sint, 0);
    do_req(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 0);

    // 5. Unmapped accesses and response backpressure
    do_req(0, 1'b0, 3'd6, 32'd0, 32'd0, 1'b1, 0);
    do_req(0, 1'b1, 3'd7, 32'h55, 32'd0, 1'b1, 0);
    do_req(0, 1'b1, 3'd5, 32'd1, 32'd0, 1'b1, 0);
    chk("t5_sw_int_unchanged", a_sint, 0);
    do_req(0, 1'b0, 3'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 5);
    do_req(0, 1'b0, 3'd2, 32'd0, 32'd0, 1'b0, 0);
    do_req(0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 0);

    // 6. PRESCALE = 4 on instance B, fresh reset
    b_arst = 1'b1;
    @(posedge clk); #1;
    b_arst = 1'b0;                                                 // after S0
    repeat (8) @(posedge clk); #1;                                 // mtime = 2
    do_req(1, 1'b0, 3'd3, 32'd0, 32'd2, 1'b0, 0);                  // ret S10
    @(posedge clk); #1;                                            // after S11
    do_req(1, 1'b0, 3'd3, 32'd0, 32'd2, 1'b0, 0);                  // ret S13
    do_req(1, 1'b0, 3'd3, 32'd0, 32'd3, 1'b0, 0);                  // ret S15
    do_req(1, 1'b1, 3'd3, 32'd100, 32'd0, 1'b0, 0);                // accept S16, tick lost
    do_req(1, 1'b0, 3'd3, 32'd0, 32'd100, 1'b0, 0);                // ret S19
    do_req(1, 1'b0, 3'd3, 32'd0, 32'd100, 1'b0, 0);                // ret S21
    do_req(1, 1'b0, 3'd3, 32'd0, 32'd101, 1'b0, 0);                // ret S23
    do_req(1, 1'b1, 3'd2, 32'd0, 32'd0, 1'b0, 0);
    do_req(1, 1'b1, 3'd1, 32'd5, 32'd0, 1'b0, 0);
    chk("t6_timer_int_set", b_tint, 1);
    do_req(1, 1'b1, 3'd0, 32'd1, 32'd0, 1'b0, 0);
    chk("t6_sw_int_set", b_sint, 1);

    // Reset while a response is pending
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'd0);
    b_rsp_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0);
    @(negedge clk);
    chk("t6_rsp_valid_pending", b_rsp_valid, 1);
    b_arst = 1'b1;
    #1;
    chk("t6_arst_rsp_valid", b_rsp_valid, 0);
    chk("t6_arst_req_ready", b_req_ready, 1);
    chk("t6_arst_timer_int", b_tint, 0);
    chk("t6_arst_sw_int", b_sint, 0);
    chk("t6_arst_rdata", b_rsp_rdata, 0);
    @(posedge clk); #1;
    b_arst = 1'b0;
    b_rsp_ready = 1'b1;
    do_req(1, 1'b0, 3'd3, 32'd0, 32'd0, 1'b0, 0);
    do_req(1, 1'b0, 3'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    do_req(1, 1'b0, 3'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
    do_req(1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 0);

    // Every issued request must have produced exactly one response.
    repeat (2) @(posedge clk);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
